// File: rtl/ahb_bus_matrix_pkg.sv
// Shared AHB bus matrix encodings and helpers.
// Used by every input stage, decoder and output stage of the matrix.
package ahb_bus_matrix_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic {
        ST_PASS = 1'b0,
        ST_HOLD = 1'b1
    } hold_state_e;

    // NONSEQ and SEQ carry a real transfer; IDLE and BUSY never do.
    function automatic logic trans_active(input logic [1:0] t);
        return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_bus_matrix_input_stage_s0.sv
// Address-phase holding stage for slave port S0 of the AHB bus matrix.
// Parks a transfer while the decoder has no granted path, then replays it.
module ahb_bus_matrix_input_stage_s0
    import ahb_bus_matrix_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int AUSER_W = 32
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic               HSELS,
    input  logic [ADDR_W-1:0]  HADDRS,
    input  logic [1:0]         HTRANSS,
    input  logic               HWRITES,
    input  logic [2:0]         HSIZES,
    input  logic [2:0]         HBURSTS,
    input  logic [3:0]         HPROTS,
    input  logic               HMASTLOCKS,
    input  logic [AUSER_W-1:0] HAUSERS,
    input  logic               HREADYS,
    input  logic               active_in,
    input  logic               readyout_in,
    input  logic [1:0]         resp_in,
    output logic               sel_in,
    output logic [ADDR_W-1:0]  addr_in,
    output logic [1:0]         trans_in,
    output logic               write_in,
    output logic [2:0]         size_in,
    output logic [2:0]         burst_in,
    output logic [3:0]         prot_in,
    output logic               mastlock_in,
    output logic [AUSER_W-1:0] auser_in,
    output logic               held_tran,
    output logic               HREADYOUTS,
    output logic [1:0]         HRESPS
);

    hold_state_e state_q, state_d;

    logic               new_tran;
    logic               load;
    logic               pend;
    logic [ADDR_W-1:0]  addr_q;
    logic [1:0]         trans_q;
    logic               write_q;
    logic [2:0]         size_q;
    logic [2:0]         burst_q;
    logic [3:0]         prot_q;
    logic               mastlock_q;
    logic [AUSER_W-1:0] auser_q;

    assign new_tran = HSELS & HREADYS & trans_active(HTRANSS);
    assign pend     = (state_q == ST_HOLD);
    assign load     = new_tran & ~active_in & ~pend;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_PASS;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_PASS: if (load) state_d = ST_HOLD;
            ST_HOLD: if (active_in && readyout_in) state_d = ST_PASS;
            default: state_d = ST_PASS;
        endcase
    end

    // Captured only on load, so contents stay frozen for the whole hold.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q     <= '0;
            trans_q    <= '0;
            write_q    <= 1'b0;
            size_q     <= '0;
            burst_q    <= '0;
            prot_q     <= '0;
            mastlock_q <= 1'b0;
            auser_q    <= '0;
        end else if (load) begin
            addr_q     <= HADDRS;
            trans_q    <= HTRANSS;
            write_q    <= HWRITES;
            size_q     <= HSIZES;
            burst_q    <= HBURSTS;
            prot_q     <= HPROTS;
            mastlock_q <= HMASTLOCKS;
            auser_q    <= HAUSERS;
        end
    end

    always_comb begin
        sel_in      = HSELS;
        addr_in     = HADDRS;
        trans_in    = HTRANSS;
        write_in    = HWRITES;
        size_in     = HSIZES;
        burst_in    = HBURSTS;
        prot_in     = HPROTS;
        mastlock_in = HMASTLOCKS;
        auser_in    = HAUSERS;
        held_tran   = 1'b0;
        HREADYOUTS  = readyout_in;
        HRESPS      = resp_in;
        if (pend) begin
            sel_in      = 1'b1;
            addr_in     = addr_q;
            trans_in    = trans_q;
            write_in    = write_q;
            size_in     = size_q;
            burst_in    = burst_q;
            prot_in     = prot_q;
            mastlock_in = mastlock_q;
            auser_in    = auser_q;
            held_tran   = 1'b1;
            HREADYOUTS  = 1'b0;
            HRESPS      = HRESP_OKAY;
        end
    end

endmodule

// File: tb/tb_ahb_bus_matrix_input_stage_s0.sv
// Directed bench for the S0 address-phase holding stage.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_ahb_bus_matrix_input_stage_s0;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSELS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [2:0]  HBURSTS;
    logic [3:0]  HPROTS;
    logic        HMASTLOCKS;
    logic [31:0] HAUSERS;
    logic        HREADYS;
    logic        active_in;
    logic        readyout_in;
    logic [1:0]  resp_in;
    logic        sel_in;
    logic [31:0] addr_in;
    logic [1:0]  trans_in;
    logic        write_in;
    logic [2:0]  size_in;
    logic [2:0]  burst_in;
    logic [3:0]  prot_in;
    logic        mastlock_in;
    logic [31:0] auser_in;
    logic        held_tran;
    logic        HREADYOUTS;
    logic [1:0]  HRESPS;

    int tests = 0;
    int fails = 0;

    always #5 HCLK = ~HCLK;

    ahb_bus_matrix_input_stage_s0 #(.ADDR_W(32), .AUSER_W(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS),
        .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES),
        .HBURSTS(HBURSTS), .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS),
        .HAUSERS(HAUSERS), .HREADYS(HREADYS), .active_in(active_in),
        .readyout_in(readyout_in), .resp_in(resp_in), .sel_in(sel_in),
        .addr_in(addr_in), .trans_in(trans_in), .write_in(write_in),
        .size_in(size_in), .burst_in(burst_in), .prot_in(prot_in),
        .mastlock_in(mastlock_in), .auser_in(auser_in),
        .held_tran(held_tran), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic sel, input logic [1:0] tr,
                       input logic [31:0] a, input logic rdys,
                       input logic act, input logic rdy,
                       input logic [1:0] rsp);
        HSELS       = sel;
        HTRANSS     = tr;
        HADDRS      = a;
        HREADYS     = rdys;
        active_in   = act;
        readyout_in = rdy;
        resp_in     = rsp;
    endtask

    initial begin
        HRESETn    = 1'b0;
        HWRITES    = 1'b0;
        HSIZES     = 3'd0;
        HBURSTS    = 3'd0;
        HPROTS     = 4'd0;
        HMASTLOCKS = 1'b0;
        HAUSERS    = 32'd0;
        drv(0, 2'b00, 32'h0, 1, 0, 1, 2'b00);
        #1;
        chk("rst_sel", 64'(sel_in), 64'd0);
        chk("rst_trans", 64'(trans_in), 64'd0);
        chk("rst_held", 64'(held_tran), 64'd0);
        chk("rst_rdy", 64'(HREADYOUTS), 64'd1);
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;

        // idle, HREADYOUTS mirrors decoder
        @(negedge HCLK);
        drv(0, 2'b00, 32'h0, 1, 0, 0, 2'b00);
        #1;
        chk("idle_sel", 64'(sel_in), 64'd0);
        chk("idle_held", 64'(held_tran), 64'd0);
        chk("idle_rdy", 64'(HREADYOUTS), 64'd0);

        // direct path
        @(negedge HCLK);
        drv(1, 2'b10, 32'h0003_0000, 1, 1, 1, 2'b00);
        #1;
        chk("dir_addr", 64'(addr_in), 64'h0003_0000);
        chk("dir_trans", 64'(trans_in), 64'd2);
        chk("dir_held", 64'(held_tran), 64'd0);
        chk("dir_rdy", 64'(HREADYOUTS), 64'd1);
        @(negedge HCLK);
        drv(0, 2'b00, 32'h0, 1, 0, 1, 2'b00);
        #1;
        chk("dir_noload", 64'(held_tran), 64'd0);

        // held path: load cycle with active_in=0
        @(negedge HCLK);
        drv(1, 2'b10, 32'h0000_1000, 1, 0, 1, 2'b00);
        HWRITES = 1'b1; HSIZES = 3'd2; HBURSTS = 3'd1;
        HPROTS = 4'h3; HMASTLOCKS = 1'b1; HAUSERS = 32'hA5A5_5A5A;
        #1;
        chk("ld_held", 64'(held_tran), 64'd0);
        chk("ld_rdy", 64'(HREADYOUTS), 64'd1);
        // three stalled cycles without grant, live bus scrambled
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            drv(i[0], 2'b00, 32'hFFFF_0000, 0, 0, 1, 2'b01);
            HWRITES = 1'b0; HSIZES = 3'd0; HBURSTS = 3'd7;
            HPROTS = 4'hC; HMASTLOCKS = 1'b0; HAUSERS = 32'h0;
            #1;
            chk("hold_held", 64'(held_tran), 64'd1);
            chk("hold_rdy", 64'(HREADYOUTS), 64'd0);
            chk("hold_resp", 64'(HRESPS), 64'd0);
            chk("hold_addr", 64'(addr_in), 64'h0000_1000);
            chk("hold_trans", 64'(trans_in), 64'd2);
            chk("hold_sel", 64'(sel_in), 64'd1);
        end
        chk("hold_write", 64'(write_in), 64'd1);
        chk("hold_size", 64'(size_in), 64'd2);
        chk("hold_burst", 64'(burst_in), 64'd1);
        chk("hold_prot", 64'(prot_in), 64'h3);
        chk("hold_lock", 64'(mastlock_in), 64'd1);
        chk("hold_auser", 64'(auser_in), 64'hA5A5_5A5A);
        // release cycle: granted and ready, still the fourth stall
        @(negedge HCLK);
        drv(1, 2'b00, 32'hFFFF_0000, 0, 1, 1, 2'b00);
        #1;
        chk("rel_held", 64'(held_tran), 64'd1);
        chk("rel_rdy", 64'(HREADYOUTS), 64'd0);
        chk("rel_addr", 64'(addr_in), 64'h0000_1000);

        // data phase: 2 wait states then 2-cycle ERROR
        @(negedge HCLK);
        drv(1, 2'b00, 32'h0, 0, 0, 0, 2'b00);
        #1;
        chk("dp0_held", 64'(held_tran), 64'd0);
        chk("dp0_rdy", 64'(HREADYOUTS), 64'd0);
        chk("dp0_trans", 64'(trans_in), 64'd0);
        @(negedge HCLK);
        drv(1, 2'b00, 32'h0, 0, 0, 0, 2'b00);
        #1;
        chk("dp1_rdy", 64'(HREADYOUTS), 64'd0);
        chk("dp1_resp", 64'(HRESPS), 64'd0);
        @(negedge HCLK);
        drv(1, 2'b00, 32'h0, 0, 0, 0, 2'b01);
        #1;
        chk("err0_rdy", 64'(HREADYOUTS), 64'd0);
        chk("err0_resp", 64'(HRESPS), 64'd1);
        @(negedge HCLK);
        drv(1, 2'b00, 32'h0, 1, 0, 1, 2'b01);
        #1;
        chk("err1_rdy", 64'(HREADYOUTS), 64'd1);
        chk("err1_resp", 64'(HRESPS), 64'd1);

        // BUSY and IDLE never load
        @(negedge HCLK);
        drv(1, 2'b01, 32'h0000_2000, 1, 0, 1, 2'b00);
        #1;
        chk("busy_held", 64'(held_tran), 64'd0);
        @(negedge HCLK);
        drv(1, 2'b00, 32'h0000_2004, 1, 0, 1, 2'b00);
        #1;
        chk("busy_noload", 64'(held_tran), 64'd0);
        chk("idle2_trans", 64'(trans_in), 64'd0);
        @(negedge HCLK);
        drv(1, 2'b00, 32'h0, 1, 0, 1, 2'b00);
        #1;
        chk("idle_noload", 64'(held_tran), 64'd0);

        // HREADYS low blocks load
        @(negedge HCLK);
        drv(1, 2'b10, 32'h0000_3000, 0, 0, 1, 2'b00);
        #1;
        @(negedge HCLK);
        drv(0, 2'b00, 32'h0, 1, 0, 1, 2'b00);
        #1;
        chk("nrdy_noload", 64'(held_tran), 64'd0);

        // SEQ is held and replayed as SEQ
        @(negedge HCLK);
        drv(1, 2'b11, 32'h0000_4004, 1, 0, 1, 2'b00);
        #1;
        @(negedge HCLK);
        drv(0, 2'b10, 32'h0, 0, 0, 0, 2'b00);
        #1;
        chk("seq_held", 64'(held_tran), 64'd1);
        chk("seq_trans", 64'(trans_in), 64'd3);
        chk("seq_addr", 64'(addr_in), 64'h0000_4004);

        // asynchronous reset mid-hold
        #1;
        HRESETn = 1'b0;
        #1;
        chk("arst_held", 64'(held_tran), 64'd0);
        chk("arst_sel", 64'(sel_in), 64'd0);
        chk("arst_rdy", 64'(HREADYOUTS), 64'd0);
        chk("arst_addr", 64'(addr_in), 64'd0);
        readyout_in = 1'b1;
        #1;
        chk("arst_rdy1", 64'(HREADYOUTS), 64'd1);
        @(negedge HCLK);
        HRESETn = 1'b1;
        drv(0, 2'b00, 32'h0, 1, 1, 1, 2'b00);
        @(negedge HCLK);
        #1;
        chk("post_held", 64'(held_tran), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
